spi_ram_controller: RTL and testbench

Single-clock SPI master that performs 32-bit word reads and writes against an external SPI SRAM using the 03h (read) and 02h (write) commands with a 24-bit address. It sits between the core's memory port and the SPI RAM pins, and the bench pairs it with the `sim_spi_ram` behavioural model. Each request is one chip-select frame: 8 command bits, 24 address bits, then 32 data bits. SPI clock runs at clk/2.

---
 rtl/spi_ram_controller_pkg.sv | 25 ++
 rtl/spi_ram_controller.sv | 186 ++++++++++++++++++
 tb/tb_spi_ram_controller.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_controller_pkg.sv
// ---------------------------------------------------------------------------
// spi_ram_controller_pkg
// Shared definitions for the SPI SRAM master: command opcodes, FSM state
// encodings and the byte-order helper used for the little-endian data field.
// ---------------------------------------------------------------------------
package spi_ram_controller_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECT   = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_DESELECT = 2'd3
  } state_t;

  // The data word travels byte 0 first, each byte MSB first. Reversing the
  // byte order turns that into a plain MSB-first 32-bit field, and the same
  // swap maps the MSB-first receive shifter back onto rdata.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_ram_controller.sv
// ---------------------------------------------------------------------------
// spi_ram_controller
// Single-clock SPI master performing 32-bit word reads (03h) and writes (02h)
// against an SPI SRAM with 24-bit addressing. One chip-select frame per
// request: 8 command bits, 24 address bits, 32 data bits. SPI clock = clk/2.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   start           request strobe, accepted only while busy is low
//   is_write        1 = write, 0 = read (sampled with start)
//   addr[23:0]      byte address (sampled with start)
//   wdata[31:0]     write word (sampled with start)
//   busy            high from the cycle after acceptance through the done cycle
//   done            one-cycle completion pulse
//   rdata[31:0]     last read word, valid from done
//   spi_clk         SPI clock, idle low
//   spi_mosi        serial data to RAM
//   spi_select      active-low chip select
//   spi_miso        serial data from RAM
// ---------------------------------------------------------------------------
module spi_ram_controller
  import spi_ram_controller_pkg::*;
#(
  parameter int unsigned DESELECT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_write,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_select,
  input  logic        spi_miso
);

  localparam int unsigned DCW = (DESELECT_CYCLES > 1) ? $clog2(DESELECT_CYCLES) : 1;
  localparam logic [DCW-1:0] DC_LAST = DCW'(DESELECT_CYCLES - 1);

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic           phase_q, phase_d;       // 0 = low phase, 1 = high phase
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           is_wr_q, is_wr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           sclk_q, sclk_d;
  logic           mosi_q, mosi_d;
  logic           sel_q, sel_d;
  logic [63:0]    tx_q, tx_d;             // tx_q[63] is the bit on the wire
  logic [31:0]    rx_q, rx_d;

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    dcnt_d  = dcnt_q;
    is_wr_d = is_wr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    sel_d   = sel_q;
    tx_d    = tx_q;
    rx_d    = rx_q;

    unique case (state_q)
      ST_IDLE: begin
        // busy stays up for the cycle in which done is visible, so a start
        // arriving alongside done is ignored and the next one is taken in
        // the following cycle.
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (start) begin
          state_d = ST_SELECT;
          busy_d  = 1'b1;
          sel_d   = 1'b0;
          is_wr_d = is_write;
          tx_d    = {(is_write ? SPI_CMD_WRITE : SPI_CMD_READ), addr,
                     (is_write ? byte_swap(wdata) : 32'h0)};
        end
      end

      ST_SELECT: begin
        state_d = ST_SHIFT;
        phase_d = 1'b0;
        cnt_d   = 6'd0;
        mosi_d  = tx_q[63];
      end

      ST_SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          sclk_d  = 1'b1;
        end else begin
          // End of high phase: sample miso, move to the next bit.
          phase_d = 1'b0;
          sclk_d  = 1'b0;
          cnt_d   = cnt_q + 6'd1;
          tx_d    = {tx_q[62:0], 1'b0};
          if (!is_wr_q && cnt_q[5]) begin
            rx_d = {rx_q[30:0], spi_miso};
          end
          if (cnt_q == 6'd63) begin
            state_d = ST_DESELECT;
            sel_d   = 1'b1;
            mosi_d  = 1'b0;
            dcnt_d  = '0;
          end else begin
            mosi_d  = tx_q[62];
          end
        end
      end

      ST_DESELECT: begin
        if (dcnt_q == DC_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (!is_wr_q) begin
            rdata_d = byte_swap(rx_q);
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      phase_q <= 1'b0;
      dcnt_q  <= '0;
      is_wr_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 32'h0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      sel_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      dcnt_q  <= dcnt_d;
      is_wr_q <= is_wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      sel_q   <= sel_d;
    end
  end

  // -------------------------------------------------------------------------
  // Shift registers (always loaded before use, so no reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign spi_clk    = sclk_q;
  assign spi_mosi   = mosi_q;
  assign spi_select = sel_q;

endmodule

// File: tb/tb_spi_ram_controller.sv
module tb_spi_ram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_write = 1'b0;
  logic [23:0] addr = 24'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done;
  logic [31:0] rdata;
  logic        spi_clk, spi_mosi, spi_select;
  logic        spi_miso = 1'b0;

  always #5 clk = ~clk;

  spi_ram_controller #(.DESELECT_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_write   (is_write),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_select (spi_select),
    .spi_miso   (spi_miso)
  );

  // ---------------- behavioural SPI SRAM (sim_spi_ram) ----------------
  logic [7:0]  mem [0:1023] = '{default: 8'h00};
  int          bcnt = 0;
  logic [31:0] hdr = 32'h0;
  logic [7:0]  byte_sh = 8'h0;
  logic [63:0] fbits = 64'h0;
  logic [63:0] last_bits = 64'h0;
  int          last_rises = 0;
  int          nframes = 0;

  always @(posedge spi_clk or posedge spi_select) begin
    if (spi_select) begin
      if (bcnt != 0) begin
        last_rises <= bcnt;
        last_bits  <= fbits;
        nframes    <= nframes + 1;
      end
      bcnt  <= 0;
      fbits <= 64'h0;
    end else begin
      fbits <= {fbits[62:0], spi_mosi};
      bcnt  <= bcnt + 1;
      if (bcnt < 32) begin
        hdr <= {hdr[30:0], spi_mosi};
      end else if (bcnt < 64) begin
        byte_sh <= {byte_sh[6:0], spi_mosi};
        if ((bcnt % 8) == 7 && hdr[31:24] == 8'h02)
          mem[hdr[9:0] + 10'((bcnt - 32) / 8)] <= {byte_sh[6:0], spi_mosi};
      end
    end
  end

  // Responder changes miso after the falling SPI clock edge.
  always @(negedge spi_clk) begin
    if (!spi_select && bcnt >= 32 && bcnt < 64 && hdr[31:24] == 8'h03)
      spi_miso <= mem[hdr[9:0] + 10'((bcnt - 32) / 8)][7 - ((bcnt - 32) % 8)];
  end

  // ---------------- cycle monitors ----------------
  int done_cnt = 0;
  int hi_run = 0;
  int last_gap = 0;
  always @(posedge clk) begin
    done_cnt <= done_cnt + int'(done);
    if (spi_select) hi_run <= hi_run + 1;
    else begin
      if (hi_run != 0) last_gap <= hi_run;
      hi_run <= 0;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic wr; logic [31:0] exp; } sb_t;
  sb_t sb_q[$];

  // One transaction from the cycle after the previous one ended. glitch_k>0
  // pulses a second start (with glitch_a) at that cycle of the frame.
  task automatic run_txn(input logic wr, input logic [23:0] a, input logic [31:0] wd,
                         input logic [31:0] exp, input int glitch_k,
                         input logic [23:0] glitch_a, input string tag);
    int   done_k, busy_n, sel_n, f0;
    sb_t  e;
    @(negedge clk);
    check({tag, " idle_before"}, {62'h0, busy, done}, 64'h0);
    f0 = nframes;
    start = 1'b1; is_write = wr; addr = a; wdata = wd;
    sb_q.push_back('{wr: wr, exp: exp});
    done_k = 0; busy_n = 0; sel_n = 0;
    for (int k = 1; k <= 400 && done_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (glitch_k != 0 && k == glitch_k) begin
        start = 1'b1; is_write = 1'b0; addr = glitch_a;
      end
      if (glitch_k != 0 && k == glitch_k + 1) start = 1'b0;
      if (busy) busy_n++;
      if (!spi_select) sel_n++;
      if (done) begin
        done_k = k;
        if (sb_q.size() == 0) check({tag, " sb_empty"}, 64'h1, 64'h0);
        else begin
          e = sb_q.pop_front();
          if (!e.wr) check({tag, " rdata"}, {32'h0, rdata}, {32'h0, e.exp});
        end
      end
    end
    if (done_k == 0) begin
      check({tag, " done_timeout"}, 64'h1, 64'h0);
      if (sb_q.size() != 0) e = sb_q.pop_front();
    end
    check({tag, " latency"}, 64'(done_k), 64'd132);
    check({tag, " busy_cycles"}, 64'(busy_n), 64'd132);
    check({tag, " sel_low_cycles"}, 64'(sel_n), 64'd129);
    check({tag, " frames"}, 64'(nframes - f0), 64'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [23:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  int d0;

  initial begin
    vecs[0] = '{1'b1, 24'h000010, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 24'h000010, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 24'h000020, 32'h00000000, 32'h0};
    vecs[3] = '{1'b0, 24'h000020, 32'h0,        32'h00000000};
    vecs[4] = '{1'b1, 24'h000024, 32'hFFFFFFFF, 32'h0};
    vecs[5] = '{1'b0, 24'h000024, 32'h0,        32'hFFFFFFFF};
    vecs[6] = '{1'b1, 24'h000031, 32'h12345678, 32'h0};
    vecs[7] = '{1'b0, 24'h000031, 32'h0,        32'h12345678};
    vecs[8] = '{1'b0, 24'h000030, 32'h0,        32'h34567800};
    vecs[9] = '{1'b1, 24'h000040, 32'hA5A55A5A, 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst spi_select", {63'h0, spi_select}, 64'h1);
    check("rst spi_clk/mosi", {62'h0, spi_clk, spi_mosi}, 64'h0);
    check("rst busy/done", {62'h0, busy, done}, 64'h0);
    check("rst rdata", {32'h0, rdata}, 64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven write/read patterns
    for (int i = 0; i < 10; i++)
      run_txn(vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].exp, 0, 24'h0, $sformatf("vec%0d", i));
    check("ram word4", {32'h0, mem[19], mem[18], mem[17], mem[16]}, {32'h0, 32'hDEADBEEF});
    run_txn(1'b0, 24'h000040, 32'h0, 32'hA5A55A5A, 0, 24'h0, "rd40");

    // Frame format of a write, then of a read
    run_txn(1'b1, 24'h123456, 32'h000000A5, 32'h0, 0, 24'h0, "fmt_wr");
    check("fmt_wr bits", last_bits, {8'h02, 24'h123456, 8'hA5, 24'h000000});
    check("fmt_wr rises", 64'(last_rises), 64'd64);
    run_txn(1'b0, 24'h000010, 32'h0, 32'hDEADBEEF, 0, 24'h0, "fmt_rd");
    check("fmt_rd bits", last_bits, {8'h03, 24'h000010, 32'h0});

    // Start during a busy read is ignored
    run_txn(1'b0, 24'h000010, 32'h0, 32'hDEADBEEF, 50, 24'h000024, "ign");
    d0 = nframes;
    repeat (10) @(negedge clk);
    check("ign no_extra_frame", 64'(nframes - d0), 64'd0);
    check("ign busy_low", {63'h0, busy}, 64'h0);

    // Back-to-back
    run_txn(1'b0, 24'h000010, 32'h0, 32'hDEADBEEF, 0, 24'h0, "b2b0");
    run_txn(1'b0, 24'h000024, 32'h0, 32'hFFFFFFFF, 0, 24'h0, "b2b1");
    check("b2b1 gap", {63'h0, (last_gap >= 3)}, 64'h1);
    run_txn(1'b1, 24'h000050, 32'hCAFEF00D, 32'h0, 0, 24'h0, "b2b2");
    check("b2b2 gap", {63'h0, (last_gap >= 3)}, 64'h1);
    run_txn(1'b0, 24'h000050, 32'h0, 32'hCAFEF00D, 0, 24'h0, "b2b_rb");

    // Reset mid-frame during a write over word 4
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1; is_write = 1'b1; addr = 24'h000010; wdata = 32'h11223344;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && bcnt != 20; k++) @(negedge clk);
    check("rstmid reached_bit20", 64'(bcnt), 64'd20);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid spi_select", {63'h0, spi_select}, 64'h1);
    check("rstmid clk/busy", {62'h0, spi_clk, busy}, 64'h0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("rstmid no_done", 64'(done_cnt - d0), 64'd0);
    check("rstmid ram", {32'h0, mem[19], mem[18], mem[17], mem[16]}, {32'h0, 32'hDEADBEEF});
    run_txn(1'b0, 24'h000010, 32'h0, 32'hDEADBEEF, 0, 24'h0, "rstmid_rd");

    check("sb drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
